spi_shift_engine: RTL and testbench
===================================

# spi_shift_engine

Parametrised frame-level SPI shift engine: loads a parallel word, shifts it out serially while capturing serial input, counts bits to a run-time frame length, and reports completion. It sits between the SPI master/slave control FSM and the pad-side clock generator, which supplies one `shift_en` strobe per SCK shift edge. It adds variable frame length, selectable bit order, abort, and a done handshake.

## Interface
- `DATA_LEN`, default `` `DATA_LEN `` (from `spi_defines.vh`): maximum frame width in bits, ≥2.
- `CNT_W`, default `$clog2(DATA_LEN+1)`: width of the bit counter and of `frame_len`.

- `clk`  in  1  single clock.
- `rst`  in  1  one clock; reset is synchronous and active-high.
- `d_in`  in  DATA_LEN  transmit word, right-aligned, sampled on accepted `start`.
- `frame_len`  in  CNT_W  bits per frame, sampled on `start`. A value of 0 or >DATA_LEN means DATA_LEN.
- `lsb_first`  in  1  bit order, sampled on `start`. 1 = LSB first.
- `start`  in  1  load and begin a frame. Accepted only when `busy`=0.
- `shift_en`  in  1  one-bit advance strobe.
- `abort`  in  1  cancel the current frame.
- `serial_in`  in  1  receive bit, sampled on `shift_en`.
- `serial_out`  out  1  current transmit bit (combinational from state).
- `d_out`  out  DATA_LEN  last completed received word, right-aligned, upper bits 0.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle completion pulse.
- `bit_cnt`  out  CNT_W  bits shifted in the current frame.

## Operation
- FSM has two states, IDLE and SHIFT. Internal registers: `sreg[DATA_LEN]`, `len`, `dir`, `cnt`.
- **IDLE + `start`:**
  - `sreg` ← `d_in` with bits ≥len cleared.
  - `len` ← effective `frame_len`; `dir` ← `lsb_first`; `cnt` ← 0.
  - Go to SHIFT. A `shift_en` in the same cycle is ignored.
- **SHIFT + `shift_en` (no `abort`):**
  - MSB-first: `sreg` ← (`sreg`<<1 | `serial_in`) masked to len bits.
  - LSB-first: `sreg` ← (`sreg`>>1) with bit len-1 = `serial_in`.
  - `cnt` ← `cnt`+1.
- **Last bit** (`shift_en` while `cnt`==len-1):
  - `d_out` ← new `sreg` value.
  - `done` ← 1 for one cycle, `cnt` ← 0, go to IDLE.
- **SHIFT + `abort`:** go to IDLE with `cnt` ← 0. No `done`; `d_out` unchanged. `abort` beats a simultaneous last `shift_en`. `abort` in IDLE has no effect.
- **`start` while `busy`:** ignored; no state change.
- **`serial_out`:** `sreg[len-1]` when MSB-first, `sreg[0]` when LSB-first. Valid in IDLE too; it holds the residual value.
- **Outputs:** `busy` = (state==SHIFT). `bit_cnt` = `cnt`.
- **Reset values:** `sreg`, `d_out`, `cnt`, `bit_cnt`, `busy`, `done`, `serial_out` are 0. State is IDLE, `len`=DATA_LEN, `dir`=MSB-first.
- **`rst` mid-frame:** everything returns to reset values at the next edge. No `done`.

## Timing
- `start` at edge N: `busy`=1 and first bit on `serial_out` from N+1.
- Each `shift_en` edge presents the next `serial_out` bit in the following cycle.
- Last `shift_en` at edge M: from M+1, `done`=1, `busy`=0, `d_out` valid. `done` drops at M+2.
- A new `start` is accepted in the `done` cycle (back-to-back frames).
- With `shift_en` held high from N+1: `done` asserts len+1 cycles after the `start` edge.
- No combinational path from inputs to `serial_out`. All other outputs are registered.

## Configuration
- Macro: `SPI_SHIFT_LSB_FIRST_EN`.
- **Defined:** `lsb_first` is honoured per frame as described.
- **Undefined:**
  - The `lsb_first` port remains but is ignored.
  - `dir` is fixed MSB-first and the LSB datapath and mux are not synthesised.
  - All other behaviour is identical.

## Test plan
All scenarios use DATA_LEN=8.
- **MSB-first loopback:** `serial_out`→`serial_in`, `d_in`=0xA5, `frame_len`=0, `shift_en` held 1 → `serial_out` 1,0,1,0,0,1,0,1; `done` 9 cycles after start; `d_out`=0xA5.
- **LSB-first constant input:** `lsb_first`=1, `d_in`=0x3C, `serial_in`=1 → `serial_out` 0,0,1,1,1,1,0,0; `d_out`=0xFF.
- **Short frame:** `frame_len`=4, MSB-first, `d_in`=0xF6, `serial_in` 1,0,0,1 → `serial_out` 0,1,1,0; `d_out`=0x09; `done` after 4 strobes.
- **Sparse strobes:** `shift_en` every 3rd cycle → `bit_cnt` steps only on strobes. `start` with `d_in`=0x00 mid-frame → ignored; frame completes with the original data.
- **Abort:** `abort` after 3 bits → `busy`=0 next cycle, no `done`, `d_out` keeps its previous value. Separately, `abort` together with the 8th `shift_en` → no `done`.
- **Reset and simultaneous start:** `rst` at bit 5 → all outputs 0 next cycle. `start`+`shift_en` in the same IDLE cycle → `bit_cnt`=0 and first bit presented. Back-to-back `start` in the `done` cycle → accepted.

Source files
------------

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: frame-level SPI shifter with run-time length, bit order (SPI_SHIFT_LSB_FIRST_EN), abort and done pulse.
// DATA_LEN defaults to `DATA_LEN from spi_defines.vh when that is defined, else 8.
`ifndef DATA_LEN
`define DATA_LEN 8
`endif
module spi_shift_engine #(
  parameter int DATA_LEN = `DATA_LEN,
  parameter int CNT_W = $clog2(DATA_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_LEN-1:0] d_in,
  input  logic [CNT_W-1:0]    frame_len,
  input  logic                lsb_first,
  input  logic                start,
  input  logic                shift_en,
  input  logic                abort,
  input  logic                serial_in,
  output logic                serial_out,
  output logic [DATA_LEN-1:0] d_out,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    bit_cnt
);
  localparam logic [0:0] IDLE = 1'b0, SHIFT = 1'b1;
  logic [0:0] state;
  logic [DATA_LEN-1:0] sreg, mask, ld_mask, msb_nxt, nxt, top_sel;
  logic [CNT_W-1:0] len, cnt, eff_len, top;
  logic last;
  assign eff_len = (frame_len == '0 || frame_len > CNT_W'(DATA_LEN)) ? CNT_W'(DATA_LEN) : frame_len;
  assign top = len - 1'b1;
  assign top_sel = DATA_LEN'(1) << top;
  assign last = cnt == top;
  always_comb begin
    mask = '0;
    ld_mask = '0;
    for (int i = 0; i < DATA_LEN; i++) begin
      mask[i] = CNT_W'(i) < len;
      ld_mask[i] = CNT_W'(i) < eff_len;
    end
  end
  assign msb_nxt = ((sreg << 1) | DATA_LEN'(serial_in)) & mask;
`ifdef SPI_SHIFT_LSB_FIRST_EN
  logic dir;
  always_ff @(posedge clk)
    if (rst) dir <= 1'b0;
    else if (state == IDLE && start) dir <= lsb_first;
  assign nxt = dir ? ((sreg >> 1) | (DATA_LEN'(serial_in) << top)) : msb_nxt;
  assign serial_out = dir ? sreg[0] : |(sreg & top_sel);
`else
  logic unused_lsb_first;
  assign unused_lsb_first = lsb_first;
  assign nxt = msb_nxt;
  assign serial_out = |(sreg & top_sel);
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sreg <= '0;
      len <= CNT_W'(DATA_LEN);
      cnt <= '0;
      d_out <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          sreg <= d_in & ld_mask;
          len <= eff_len;
          cnt <= '0;
          state <= SHIFT;
        end
      end else if (abort) begin
        state <= IDLE;
        cnt <= '0;
      end else if (shift_en) begin
        sreg <= nxt;
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) begin
          d_out <= nxt;
          done <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end
  assign busy = state == SHIFT;
  assign bit_cnt = cnt;
endmodule

// File: tb/tb_spi_shift_engine.sv
// tb_spi_shift_engine: directed plus random stimulus against a bit-stream queue model of the shift engine.
module tb_spi_shift_engine;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, shift_en = 1'b0, abort = 1'b0, serial_in = 1'b0, lsb_first = 1'b0;
  logic [7:0] d_in = '0;
  logic [3:0] frame_len = '0;
  logic serial_out, busy, done;
  logic [7:0] d_out;
  logic [3:0] bit_cnt;
  int checks = 0, errors = 0;
  bit m_busy, m_done, m_dir;
  int m_len, m_cnt;
  logic [7:0] m_dout;
  bit q[$];

  spi_shift_engine #(.DATA_LEN(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .frame_len(frame_len), .lsb_first(lsb_first),
    .start(start), .shift_en(shift_en), .abort(abort), .serial_in(serial_in),
    .serial_out(serial_out), .d_out(d_out), .busy(busy), .done(done), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line model: q holds the bits still to appear on serial_out, received bits join at the back.
  task automatic model_step();
    if (rst) begin
      m_busy = 0; m_done = 0; m_dir = 0; m_len = 8; m_cnt = 0; m_dout = '0;
      q = {};
      for (int i = 0; i < 8; i++) q.push_back(1'b0);
    end else if (!m_busy) begin
      m_done = 0;
      if (start) begin
        m_len = (frame_len == 0 || frame_len > 8) ? 8 : int'(frame_len);
`ifdef SPI_SHIFT_LSB_FIRST_EN
        m_dir = lsb_first;
`else
        m_dir = 0;
`endif
        q = {};
        for (int i = 0; i < m_len; i++) q.push_back(m_dir ? d_in[i] : d_in[m_len-1-i]);
        m_cnt = 0;
        m_busy = 1;
      end
    end else begin
      m_done = 0;
      if (abort) begin
        m_busy = 0; m_cnt = 0;
      end else if (shift_en) begin
        void'(q.pop_front());
        q.push_back(serial_in);
        m_cnt++;
        if (m_cnt == m_len) begin
          m_dout = '0;
          for (int i = 0; i < m_len; i++)
            if (m_dir) m_dout[i] = q[i]; else m_dout[m_len-1-i] = q[i];
          m_done = 1; m_busy = 0; m_cnt = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("bit_cnt", bit_cnt, m_cnt);
    check("d_out", d_out, m_dout);
    check("serial_out", serial_out, q[0]);
  endtask

  task automatic begin_frame(input logic [7:0] d, input logic [3:0] fl, input logic lsb);
    d_in = d; frame_len = fl; lsb_first = lsb; start = 1;
    tick();
    start = 0;
  endtask

  initial begin
    logic [7:0] pat, saved;
    int lat, n;
    rst = 1;
    tick();
    rst = 0;
    check("rst_busy", busy, 0);
    check("rst_sout", serial_out, 0);
    // MSB-first loopback
    pat = 8'hA5;
    begin_frame(8'hA5, 4'd0, 1'b0);
    shift_en = 1;
    lat = 1; n = 0;
    while (!done && lat < 20) begin
      if (n < 8) check("lb_sout", serial_out, pat[7-n]);
      n++;
      serial_in = serial_out;
      tick();
      lat++;
    end
    check("lb_latency", lat, 9);
    check("lb_dout", d_out, 8'hA5);
    // LSB-first, constant input
    shift_en = 0; serial_in = 1;
    begin_frame(8'h3C, 4'd8, 1'b1);
    shift_en = 1;
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    check("lsb_done", done, 1);
    check("lsb_dout", d_out, 8'hFF);
    // Short frame, started together with a shift_en that must be ignored
    pat = 8'h09;
    d_in = 8'hF6; frame_len = 4; lsb_first = 0; start = 1; shift_en = 1;
    tick();
    start = 0;
    check("sim_start_cnt", bit_cnt, 0);
    saved = 8'h06;
    for (int i = 0; i < 4; i++) begin
      check("short_sout", serial_out, saved[3-i]);
      serial_in = pat[3-i];
      tick();
    end
    check("short_done", done, 1);
    check("short_dout", d_out, 8'h09);
    // Sparse strobes with an ignored mid-frame start
    shift_en = 0;
    begin_frame(8'h5B, 4'd0, 1'b0);
    n = 0;
    while (!done && n < 60) begin
      shift_en = (n % 3 == 2);
      serial_in = 1'($urandom);
      start = (n == 7); d_in = 8'h00;
      tick();
      n++;
    end
    start = 0; shift_en = 0;
    check("sparse_done", done, 1);
    // Back-to-back start in the done cycle, then abort after 3 bits
    saved = d_out;
    begin_frame(8'hC3, 4'd0, 1'b0);
    check("b2b_busy", busy, 1);
    shift_en = 1;
    repeat (3) begin serial_in = 1'($urandom); tick(); end
    shift_en = 0; abort = 1;
    tick();
    abort = 0;
    check("abort_busy", busy, 0);
    check("abort_dout", d_out, saved);
    tick();
    check("abort_nodone", done, 0);
    // Abort together with the last strobe
    begin_frame(8'h81, 4'd0, 1'b0);
    shift_en = 1;
    repeat (7) tick();
    abort = 1;
    tick();
    abort = 0; shift_en = 0;
    check("abort_last_done", done, 0);
    check("abort_last_busy", busy, 0);
    // Reset at bit 5
    begin_frame(8'hFF, 4'd0, 1'b0);
    shift_en = 1; serial_in = 1;
    repeat (5) tick();
    rst = 1;
    tick();
    rst = 0; shift_en = 0;
    check("midrst_all", {serial_out, d_out, busy, done, bit_cnt}, 0);
    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(199) == 0);
      start = ($urandom_range(3) == 0);
      shift_en = 1'($urandom);
      abort = ($urandom_range(29) == 0);
      serial_in = 1'($urandom);
      lsb_first = 1'($urandom);
      d_in = 8'($urandom);
      frame_len = 4'($urandom);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
